// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state codes, opcode/func encodings, datapath mux codes and the
//   decoded instruction-class struct shared by the multi-cycle controller.
// Latency: n/a (types and constants only).  Backpressure: n/a.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    MC_STATE_FETCH  = 3'd0,
    MC_STATE_DECODE = 3'd1,
    MC_STATE_EXEC   = 3'd2,
    MC_STATE_MEM    = 3'd3,
    MC_STATE_WB     = 3'd4
  } mc_state_t;

  // Opcode and function encodings of the supported instructions.
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;
  localparam logic [5:0] FUNC_JR   = 6'h08;
  localparam logic [5:0] FUNC_ADDU = 6'h21;
  localparam logic [5:0] FUNC_SUBU = 6'h23;

  // Datapath select codes, shared with the single-cycle datapath.
  localparam logic [1:0] REG_DST_RD = 2'd0;
  localparam logic [1:0] REG_DST_RT = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] REG_DATA_ALU = 2'd0;
  localparam logic [1:0] REG_DATA_MEM = 2'd1;
  localparam logic [1:0] REG_DATA_PC4 = 2'd2;

  localparam logic ALU_SRC_RT  = 1'b0;
  localparam logic ALU_SRC_EXT = 1'b1;

  localparam logic [2:0] ALU_OP_ADD  = 3'd0;
  localparam logic [2:0] ALU_OP_SUB  = 3'd1;
  localparam logic [2:0] ALU_OP_OR   = 3'd2;
  localparam logic [2:0] ALU_OP_EQ   = 3'd3;
  localparam logic [2:0] ALU_OP_SL16 = 3'd4;

  localparam logic [1:0] JUMP_MODE_NEXT   = 2'd0;
  localparam logic [1:0] JUMP_MODE_OFFSET = 2'd1;
  localparam logic [1:0] JUMP_MODE_ABS    = 2'd2;
  localparam logic [1:0] JUMP_MODE_INPUT  = 2'd3;

  localparam logic EXT_OP_ZERO   = 1'b0;
  localparam logic EXT_OP_SIGNED = 1'b1;

  // One-hot instruction class; exactly one field is set for any encoding.
  typedef struct packed {
    logic r_alu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
    logic jr;
    logic unknown;
  } instr_class_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: controller <-> datapath bundle. master = controller (drives the
//   strobes/selects), slave = datapath (drives op/func/cmp_true/mem_ready).
// Latency: n/a.  Backpressure: mem_ready only when MC_CTRL_MEM_WAIT_EN is defined.
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       cmp_true;
`ifdef MC_CTRL_MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       pc_write;
  logic [1:0] jump_mode;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       mem_addr_src;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] reg_data;
  logic       alu_src;
  logic [2:0] alu_op;
  logic       ext_op;
  logic [2:0] state;
  logic       instr_done;

  modport master (
`ifdef MC_CTRL_MEM_WAIT_EN
    input  mem_ready,
`endif
    input  op, func, cmp_true,
    output pc_write, jump_mode, ir_write, mem_read, mem_write, mem_addr_src,
    output reg_write, reg_dst, reg_data, alu_src, alu_op, ext_op,
    output state, instr_done
  );

  modport slave (
`ifdef MC_CTRL_MEM_WAIT_EN
    output mem_ready,
`endif
    output op, func, cmp_true,
    input  pc_write, jump_mode, ir_write, mem_read, mem_write, mem_addr_src,
    input  reg_write, reg_dst, reg_data, alu_src, alu_op, ext_op,
    input  state, instr_done
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_decode: classifies op/func into a one-hot instruction class.
// Latency: combinational.  Backpressure: none.
// Ports: op, func in; cls (instr_class_t) out.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   func,
  output instr_class_t cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        if (func == FUNC_ADDU || func == FUNC_SUBU) cls.r_alu   = 1'b1;
        else if (func == FUNC_JR)                   cls.jr      = 1'b1;
        else                                        cls.unknown = 1'b1;
      end
      OP_ORI:  cls.ori     = 1'b1;
      OP_LUI:  cls.lui     = 1'b1;
      OP_LW:   cls.lw      = 1'b1;
      OP_SW:   cls.sw      = 1'b1;
      OP_BEQ:  cls.beq     = 1'b1;
      OP_JAL:  cls.jal     = 1'b1;
      default: cls.unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) driving the
//   datapath strobes from the state register and the latched IR fields.
// Latency: 2..5 cycles per instruction; outputs combinational on state/op/func/cmp_true.
// Backpressure: with MC_CTRL_MEM_WAIT_EN, FETCH and MEM stall while bus.mem_ready=0.
// Ports: clk, reset (sync, active-high), bus (mc_ctrl_if.master).
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input logic       clk,
  input logic       reset,
  mc_ctrl_if.master bus
);

  mc_state_t    state_q;
  mc_state_t    state_d;
  instr_class_t cls;
  logic         mem_ok;

  mc_decode u_decode (
    .op   (bus.op),
    .func (bus.func),
    .cls  (cls)
  );

`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= MC_STATE_FETCH;
    else       state_q <= state_d;
  end

  assign bus.state = state_q;

  always_comb begin
    state_d          = state_q;
    bus.pc_write     = 1'b0;
    bus.jump_mode    = JUMP_MODE_NEXT;
    bus.ir_write     = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_addr_src = 1'b0;
    bus.reg_write    = 1'b0;
    bus.reg_dst      = REG_DST_RD;
    bus.reg_data     = REG_DATA_ALU;
    bus.alu_src      = ALU_SRC_RT;
    bus.alu_op       = ALU_OP_ADD;
    bus.ext_op       = EXT_OP_ZERO;
    bus.instr_done   = 1'b0;

    case (state_q)
      MC_STATE_FETCH: begin
        // Read stays up while waiting; the IR/PC loads happen on the completing cycle.
        bus.mem_read = 1'b1;
        bus.ir_write = mem_ok;
        bus.pc_write = mem_ok;
        if (mem_ok) state_d = MC_STATE_DECODE;
      end
      MC_STATE_DECODE: begin
        if (cls.jal) begin
          // PC already holds PC+4 from FETCH, so it is the link value.
          bus.reg_write  = 1'b1;
          bus.reg_dst    = REG_DST_RA;
          bus.reg_data   = REG_DATA_PC4;
          bus.pc_write   = 1'b1;
          bus.jump_mode  = JUMP_MODE_ABS;
          bus.instr_done = 1'b1;
          state_d        = MC_STATE_FETCH;
        end else if (cls.jr) begin
          bus.pc_write   = 1'b1;
          bus.jump_mode  = JUMP_MODE_INPUT;
          bus.instr_done = 1'b1;
          state_d        = MC_STATE_FETCH;
        end else if (cls.unknown) begin
          bus.instr_done = 1'b1;
          state_d        = MC_STATE_FETCH;
        end else begin
          state_d = MC_STATE_EXEC;
        end
      end
      MC_STATE_EXEC: begin
        if (cls.r_alu) begin
          bus.alu_op = (bus.func == FUNC_SUBU) ? ALU_OP_SUB : ALU_OP_ADD;
          state_d    = MC_STATE_WB;
        end else if (cls.ori) begin
          bus.alu_src = ALU_SRC_EXT;
          bus.alu_op  = ALU_OP_OR;
          state_d     = MC_STATE_WB;
        end else if (cls.lui) begin
          bus.alu_src = ALU_SRC_EXT;
          bus.alu_op  = ALU_OP_SL16;
          state_d     = MC_STATE_WB;
        end else if (cls.lw || cls.sw) begin
          bus.alu_src = ALU_SRC_EXT;
          bus.ext_op  = EXT_OP_SIGNED;
          state_d     = MC_STATE_MEM;
        end else if (cls.beq) begin
          bus.alu_op     = ALU_OP_EQ;
          bus.pc_write   = bus.cmp_true;
          bus.jump_mode  = JUMP_MODE_OFFSET;
          bus.instr_done = 1'b1;
          state_d        = MC_STATE_FETCH;
        end else begin
          // Only reachable if op changed under us; recover without writing.
          state_d = MC_STATE_FETCH;
        end
      end
      MC_STATE_MEM: begin
        bus.mem_addr_src = 1'b1;
        if (cls.sw) begin
          bus.mem_write  = 1'b1;
          bus.instr_done = mem_ok;
          if (mem_ok) state_d = MC_STATE_FETCH;
        end else if (cls.lw) begin
          bus.mem_read = 1'b1;
          if (mem_ok) state_d = MC_STATE_WB;
        end else begin
          state_d = MC_STATE_FETCH;
        end
      end
      MC_STATE_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = cls.r_alu ? REG_DST_RD : REG_DST_RT;
        bus.reg_data   = cls.lw ? REG_DATA_MEM : REG_DATA_ALU;
        bus.instr_done = 1'b1;
        state_d        = MC_STATE_FETCH;
      end
      default: state_d = MC_STATE_FETCH;
    endcase

    // Reset kills every strobe and select in the same cycle so a partial
    // instruction can never commit an architectural write.
    if (reset) begin
      bus.pc_write     = 1'b0;
      bus.jump_mode    = JUMP_MODE_NEXT;
      bus.ir_write     = 1'b0;
      bus.mem_read     = 1'b0;
      bus.mem_write    = 1'b0;
      bus.mem_addr_src = 1'b0;
      bus.reg_write    = 1'b0;
      bus.reg_dst      = REG_DST_RD;
      bus.reg_data     = REG_DATA_ALU;
      bus.alu_src      = ALU_SRC_RT;
      bus.alu_op       = ALU_OP_ADD;
      bus.ext_op       = EXT_OP_ZERO;
      bus.instr_done   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven bench for mc_ctrl with a per-instruction scoreboard.
// Latency: n/a.  Backpressure: exercises mem_ready stalls when MC_CTRL_MEM_WAIT_EN is defined.
module tb_mc_ctrl;

  logic clk;
  logic reset;
  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-instruction summary: counts of strobe cycles, state trace
  // (3 bits per cycle, first cycle in the low bits) and captured selects.
  typedef struct {
    int   idx;
    logic [5:0] op;
    logic [5:0] func;
    logic cmp;
    int   cyc, seq, n_pc, n_ir, n_rw, n_mw, n_mr, n_addr1, n_conf;
    int   rd, rdat, jm, aop, asrc, eop;
  } vec_t;

  localparam int NV = 12;
  vec_t  vecs [NV];
  string names [NV];
  vec_t  sb_q [$];

  int checks = 0;
  int errors = 0;
  bit sb_en  = 1'b1;

  task automatic chk(input string what, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", what, got, exp);
    end
  endtask

  // Monitor accumulators for the instruction in flight.
  int m_cyc, m_seq, m_pc, m_ir, m_rw, m_mw, m_mr, m_addr1, m_conf, m_fbad;
  int m_rd, m_rdat, m_jm, m_aop, m_asrc, m_eop;

  task automatic m_clear();
    m_cyc = 0; m_seq = 0; m_pc = 0; m_ir = 0; m_rw = 0; m_mw = 0; m_mr = 0;
    m_addr1 = 0; m_conf = 0; m_fbad = 0;
    m_rd = 0; m_rdat = 0; m_jm = 0; m_aop = 0; m_asrc = 0; m_eop = 0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      m_clear();
    end else begin
      if (m_cyc < 5) m_seq = m_seq | (int'(bus.state) << (3 * m_cyc));
      m_cyc++;
      m_pc    += int'(bus.pc_write);
      m_ir    += int'(bus.ir_write);
      m_rw    += int'(bus.reg_write);
      m_mw    += int'(bus.mem_write);
      m_mr    += int'(bus.mem_read);
      m_addr1 += int'(bus.mem_addr_src);
      if (int'(bus.pc_write) + int'(bus.mem_write) + int'(bus.reg_write) >= 2) m_conf++;
      if (bus.state == 3'd0 &&
          !(bus.mem_read && !bus.mem_addr_src && bus.ir_write && bus.pc_write &&
            bus.jump_mode == 2'd0)) m_fbad++;
      if (bus.state == 3'd2) begin
        m_aop = int'(bus.alu_op); m_asrc = int'(bus.alu_src); m_eop = int'(bus.ext_op);
      end
      if (bus.reg_write) begin
        m_rd = int'(bus.reg_dst); m_rdat = int'(bus.reg_data);
      end
      if (bus.pc_write && bus.state != 3'd0) m_jm = int'(bus.jump_mode);
      if (bus.instr_done) begin
        if (sb_en) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_instr_done", 1, 0);
          end else begin
            vec_t e;
            string n;
            e = sb_q.pop_front();
            n = names[e.idx];
            chk({n, ".cycles"},    m_cyc,   e.cyc);
            chk({n, ".state_seq"}, m_seq,   e.seq);
            chk({n, ".pc_write"},  m_pc,    e.n_pc);
            chk({n, ".ir_write"},  m_ir,    e.n_ir);
            chk({n, ".reg_write"}, m_rw,    e.n_rw);
            chk({n, ".mem_write"}, m_mw,    e.n_mw);
            chk({n, ".mem_read"},  m_mr,    e.n_mr);
            chk({n, ".addr_src1"}, m_addr1, e.n_addr1);
            chk({n, ".conflict"},  m_conf,  e.n_conf);
            chk({n, ".fetch_out"}, m_fbad,  0);
            chk({n, ".reg_dst"},   m_rd,    e.rd);
            chk({n, ".reg_data"},  m_rdat,  e.rdat);
            chk({n, ".jump_mode"}, m_jm,    e.jm);
            chk({n, ".alu_op"},    m_aop,   e.aop);
            chk({n, ".alu_src"},   m_asrc,  e.asrc);
            chk({n, ".ext_op"},    m_eop,   e.eop);
          end
        end
        m_clear();
      end
    end
  end

  task automatic apply(input int i);
    bus.op       = vecs[i].op;
    bus.func     = vecs[i].func;
    bus.cmp_true = vecs[i].cmp;
    sb_q.push_back(vecs[i]);
  endtask

  task automatic wait_done(input string what);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (bus.instr_done) seen = 1'b1;
    end
    if (!seen) chk({what, ".timeout"}, 0, 1);
  endtask

  task automatic chk_reset_quiet(input string what);
    chk({what, ".strobes"},
        int'({bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write,
              bus.reg_write, bus.instr_done}), 0);
    chk({what, ".selects"},
        int'({bus.jump_mode, bus.reg_dst, bus.reg_data, bus.alu_src,
              bus.alu_op, bus.ext_op, bus.mem_addr_src}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          idx op     func   cmp cyc seq      pc ir rw mw mr a1 cf rd rdat jm aop asrc eop
    vecs[0]  = '{0,  6'h00, 6'h21, 0, 4, 'h888,  1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1,  6'h00, 6'h23, 0, 4, 'h888,  1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[2]  = '{2,  6'h0d, 6'h21, 0, 4, 'h888,  1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 2, 1, 0};
    vecs[3]  = '{3,  6'h0f, 6'h00, 0, 4, 'h888,  1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 4, 1, 0};
    vecs[4]  = '{4,  6'h23, 6'h00, 0, 5, 'h4688, 1, 1, 1, 0, 2, 1, 0, 1, 1, 0, 0, 1, 1};
    vecs[5]  = '{5,  6'h2b, 6'h00, 0, 4, 'h688,  1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
    vecs[6]  = '{6,  6'h04, 6'h00, 1, 3, 'h88,   2, 1, 0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0};
    vecs[7]  = '{7,  6'h04, 6'h00, 0, 3, 'h88,   1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0};
    vecs[8]  = '{8,  6'h03, 6'h00, 0, 2, 'h8,    2, 1, 1, 0, 1, 0, 1, 2, 2, 2, 0, 0, 0};
    vecs[9]  = '{9,  6'h00, 6'h08, 0, 2, 'h8,    2, 1, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0};
    vecs[10] = '{10, 6'h3f, 6'h00, 0, 2, 'h8,    1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{11, 6'h00, 6'h00, 0, 2, 'h8,    1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    names = '{"addu", "subu", "ori", "lui", "lw", "sw", "beq_t", "beq_nt",
              "jal", "jr", "unk_op", "unk_func"};

    m_clear();
    reset        = 1'b1;
    bus.op       = 6'h00;
    bus.func     = 6'h21;
    bus.cmp_true = 1'b0;
`ifdef MC_CTRL_MEM_WAIT_EN
    bus.mem_ready = 1'b1;
`endif

    // Reset held for 3 cycles: everything quiet, state parked in FETCH.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_reset_quiet("reset_hold");
      chk("reset_hold.state", int'(bus.state), 0);
    end

    // First instruction (addu) released straight out of reset.
    apply(0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_done(names[0]);

    for (int i = 1; i < NV; i++) begin
      @(posedge clk); #1;
      apply(i);
      wait_done(names[i]);
    end

    // sw interrupted by reset in MEM: no mem_write may escape.
    @(posedge clk); #1;
    bus.op = 6'h2b; bus.func = 6'h00;
    begin
      bit in_exec;
      in_exec = 1'b0;
      for (int k = 0; k < 10 && !in_exec; k++) begin
        @(negedge clk);
        chk("sw_abort.pre_mem_write", int'(bus.mem_write), 0);
        if (bus.state == 3'd2) in_exec = 1'b1;
      end
      if (!in_exec) chk("sw_abort.reach_exec", 0, 1);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("sw_abort.state_mem", int'(bus.state), 3);
    chk_reset_quiet("sw_abort.mem");
    @(posedge clk); #1;
    @(negedge clk);
    chk("sw_abort.state_fetch", int'(bus.state), 0);
    chk_reset_quiet("sw_abort.hold");
    // Released again: the next cycle must be FETCH of a fresh addu.
    apply(0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_done("after_abort");

`ifdef MC_CTRL_MEM_WAIT_EN
    // lw with 3 stalled FETCH cycles and 2 stalled MEM cycles: 10 cycles total.
    begin
      int fw, mw, cyc, irc, fcnt, mcnt;
      bit done;
      fw = 3; mw = 2; cyc = 0; irc = 0; fcnt = 0; mcnt = 0; done = 1'b0;
      sb_en = 1'b0;
      @(posedge clk);
      for (int k = 0; k < 40 && !done; k++) begin
        #1;
        bus.op = 6'h23; bus.func = 6'h00;
        if (bus.state == 3'd0 && fw > 0) begin
          bus.mem_ready = 1'b0; fw--;
        end else if (bus.state == 3'd3 && mw > 0) begin
          bus.mem_ready = 1'b0; mw--;
        end else begin
          bus.mem_ready = 1'b1;
        end
        @(negedge clk);
        cyc++;
        irc += int'(bus.ir_write);
        if (bus.state == 3'd0) fcnt++;
        if (bus.state == 3'd3) mcnt++;
        if (bus.instr_done) done = 1'b1;
        else @(posedge clk);
      end
      chk("lw_wait.done",        int'(done), 1);
      chk("lw_wait.cycles",      cyc, 10);
      chk("lw_wait.ir_write",    irc, 1);
      chk("lw_wait.fetch_cycles", fcnt, 4);
      chk("lw_wait.mem_cycles",  mcnt, 3);
      bus.mem_ready = 1'b1;
      sb_en = 1'b1;
    end
`endif

    @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
